imem_port_arbiter: RTL and testbench
====================================

Name: imem_port_arbiter

Overview:
- Shares the single instruction-memory port between the fetch stage (PC-driven fetches) and a loader/debug requester that reads and writes imem.
- One outstanding memory transaction at a time.
- Routes each response to its owner. Swallows the response of a fetch killed by a pipeline flush.
- Bounds loader bursts so fetch cannot starve.
- Sits between fetch_stage (imem_req/imem_req_addr/imem_data/imem_resp) and the imem macro.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, XLEN_WIDTH, data width.
- LOAD_BURST_MAX, 4, max consecutive loader grants while a fetch is pending (≥1).

Ports:
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- f_req  in  1  fetch request (fetch_stage imem_req)
- f_addr  in  ADDR_W  fetch address; held stable until f_resp
- f_kill  in  1  flush (PC_flush); kills the pending/in-flight fetch
- f_resp  out  1  fetch data valid, 1-cycle pulse
- f_data  out  DATA_W  fetch data
- l_req  in  1  loader request
- l_we  in  1  loader write enable
- l_addr  in  ADDR_W  loader address
- l_wdata  in  DATA_W  loader write data
- l_gnt  out  1  loader request accepted this cycle
- l_resp  out  1  loader completion pulse (read data or write ack)
- l_rdata  out  DATA_W  loader read data
- mem_req  out  1  memory request, 1-cycle pulse
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_resp  in  1  memory response pulse, ≥1 cycle after mem_req
- mem_rdata  in  DATA_W  memory read data, valid with mem_resp
- busy  out  1  transaction outstanding
- err_stray  out  1  sticky: mem_resp seen with nothing outstanding

Behaviour:
- Clock clk. Reset reset_n: synchronous, active-low.
- Reset state: IDLE, burst_cnt=0. mem_req, f_resp, l_resp, l_gnt, busy and err_stray are all 0. Data outputs are 0.
- States:
  - IDLE: no transaction outstanding.
  - F_WAIT: fetch outstanding.
  - L_WAIT: loader outstanding.
  - F_DROP: killed fetch outstanding; its response is discarded.
- Issue (IDLE only, combinational): fetch is eligible when f_req && !f_kill.
  - Only one requester eligible: it wins.
  - Both eligible: loader wins unless burst_cnt == LOAD_BURST_MAX, in which case fetch wins.
  - Winner drives mem_req=1 with mem_addr/mem_we/mem_wdata for exactly that cycle.
  - Fetch issue: mem_we=0, next state F_WAIT. Loader issue: l_gnt=1, next state L_WAIT.
- burst_cnt (registered):
  - +1 on a loader grant while fetch is eligible; saturates at LOAD_BURST_MAX.
  - Cleared on a fetch grant, or in any cycle fetch is not eligible.
- F_WAIT:
  - mem_resp && !f_kill: f_resp=1, f_data=mem_rdata, next state IDLE.
  - f_kill && mem_resp (same cycle): drop the response (f_resp=0), next state IDLE.
  - f_kill without mem_resp: next state F_DROP.
- F_DROP: on mem_resp, discard it (no f_resp, no l_resp), next state IDLE. f_kill is ignored in this state.
- L_WAIT: on mem_resp, l_resp=1 and l_rdata=mem_rdata (don't-care for writes), next state IDLE. f_kill is ignored.
- Throughput: no issue in the cycle mem_resp returns. The earliest next issue is the following cycle (IDLE). Minimum 2 cycles per transaction at memory latency 1.
- busy = (state != IDLE).
- mem_resp in IDLE sets err_stray. err_stray clears only on reset.
- Reset while a transaction is outstanding: return to IDLE. A late mem_resp then sets err_stray. Memory must be reset together with the arbiter.
- f_data/l_rdata hold their last values between responses.

Decomposition:
- Shared package common: state enum imem_arb_state_t (IDLE, F_WAIT, L_WAIT, F_DROP); constant IMEM_LOAD_BURST_MAX default 4.
- XLEN_WIDTH comes from common.
- No sub-module: FSM plus burst counter in one module.

Test Plan:
- Fetch only, memory latency 1, f_addr=0x100, mem_rdata=0x00000013:
  - mem_req at t0 with addr 0x100, we=0.
  - f_resp at t1 with f_data=0x13.
  - Next mem_req at t2 at the earliest.
- Loader write addr 0x40, wdata 0xDEADBEEF, latency 3: l_gnt and mem_req with we=1 at t0; l_resp at t3; busy high t0+1..t3.
- f_req and l_req held continuously (both eligible), LOAD_BURST_MAX=4: grant order L,L,L,L,F,L,L,L,L,F; burst_cnt is 0 after each fetch grant.
- Fetch issued at t0, latency 4, f_kill pulsed at t1: state goes to F_DROP; mem_resp at t4 produces no f_resp; a new fetch to 0x200 issues at t5.
- f_kill coincident with mem_resp in F_WAIT: f_resp stays 0 and the next state is IDLE. f_kill held in IDLE with f_req=1: no mem_req.
- Spurious mem_resp in IDLE, and reset_n low mid-L_WAIT followed by a late mem_resp: err_stray=1 and no l_resp; err_stray=0 after the next reset.

Source files
------------

// File: rtl/imem_port_arbiter_pkg.sv
// Shared types and defaults for the instruction-memory port arbiter.
package imem_port_arbiter_pkg;

  localparam int unsigned XLEN_WIDTH          = 32;
  localparam int unsigned IMEM_LOAD_BURST_MAX = 4;

  typedef enum logic [1:0] {
    IDLE,
    F_WAIT,
    L_WAIT,
    F_DROP
  } imem_arb_state_t;

endpackage

// File: rtl/imem_port_arbiter_if.sv
// Fetch, loader and imem signals around the arbiter.
// master = the arbiter itself, slave = fetch stage, loader and memory.
interface imem_port_arbiter_if
  import imem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = XLEN_WIDTH
) ();

  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_kill;
  logic              f_resp;
  logic [DATA_W-1:0] f_data;

  logic              l_req;
  logic              l_we;
  logic [ADDR_W-1:0] l_addr;
  logic [DATA_W-1:0] l_wdata;
  logic              l_gnt;
  logic              l_resp;
  logic [DATA_W-1:0] l_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_resp;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              err_stray;

  modport master (
    input  f_req, f_addr, f_kill,
    output f_resp, f_data,
    input  l_req, l_we, l_addr, l_wdata,
    output l_gnt, l_resp, l_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_resp, mem_rdata,
    output busy, err_stray
  );

  modport slave (
    output f_req, f_addr, f_kill,
    input  f_resp, f_data,
    output l_req, l_we, l_addr, l_wdata,
    input  l_gnt, l_resp, l_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_resp, mem_rdata,
    input  busy, err_stray
  );

endinterface

// File: rtl/imem_port_arbiter.sv
// Shares the single imem port between fetch and the loader/debug requester,
// one transaction in flight, with bounded loader bursts and flush-drop of fetches.
module imem_port_arbiter
  import imem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = XLEN_WIDTH,
  parameter int unsigned LOAD_BURST_MAX = IMEM_LOAD_BURST_MAX
) (
  input  logic                 clk,
  input  logic                 reset_n,
  imem_port_arbiter_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(LOAD_BURST_MAX + 1);

  imem_arb_state_t   r_state;
  logic [CNT_W-1:0]  r_burst_cnt;
  logic              r_err_stray;
  logic [DATA_W-1:0] r_f_data;
  logic [DATA_W-1:0] r_l_rdata;

  logic w_f_elig;
  logic w_burst_full;
  logic w_idle;
  logic w_f_win;
  logic w_l_win;
  logic w_f_done;
  logic w_l_done;

  // Issue/response strobes are gated by reset_n so every pulse output is
  // quiet while reset is held, whatever state the register still shows.
  always_comb begin
    w_f_elig     = bus.f_req && !bus.f_kill;
    w_burst_full = (r_burst_cnt == CNT_W'(LOAD_BURST_MAX));
    w_idle       = reset_n && (r_state == IDLE);
    w_f_win      = w_idle && w_f_elig && (!bus.l_req || w_burst_full);
    w_l_win      = w_idle && bus.l_req && !(w_f_elig && w_burst_full);
    w_f_done     = reset_n && (r_state == F_WAIT) && bus.mem_resp && !bus.f_kill;
    w_l_done     = reset_n && (r_state == L_WAIT) && bus.mem_resp;
  end

  always_comb begin
    bus.mem_req   = w_f_win || w_l_win;
    bus.mem_we    = w_l_win && bus.l_we;
    bus.mem_addr  = w_l_win ? bus.l_addr : (w_f_win ? bus.f_addr : '0);
    bus.mem_wdata = (w_l_win && bus.l_we) ? bus.l_wdata : '0;
    bus.l_gnt     = w_l_win;
    bus.f_resp    = w_f_done;
    bus.f_data    = w_f_done ? bus.mem_rdata : r_f_data;
    bus.l_resp    = w_l_done;
    bus.l_rdata   = w_l_done ? bus.mem_rdata : r_l_rdata;
    bus.busy      = (r_state != IDLE);
    bus.err_stray = r_err_stray;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_burst_cnt <= '0;
      r_err_stray <= 1'b0;
      r_f_data    <= '0;
      r_l_rdata   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (bus.mem_resp) r_err_stray <= 1'b1;
          if (w_f_win)      r_state <= F_WAIT;
          else if (w_l_win) r_state <= L_WAIT;
        end
        F_WAIT: begin
          if (bus.mem_resp) begin
            r_state <= IDLE;
            if (!bus.f_kill) r_f_data <= bus.mem_rdata;
          end else if (bus.f_kill) begin
            r_state <= F_DROP;
          end
        end
        F_DROP: begin
          if (bus.mem_resp) r_state <= IDLE;
        end
        L_WAIT: begin
          if (bus.mem_resp) begin
            r_state   <= IDLE;
            r_l_rdata <= bus.mem_rdata;
          end
        end
        default: r_state <= IDLE;
      endcase

      // Streak of loader wins over a waiting fetch; any gap in fetch demand resets it.
      if (!w_f_elig || w_f_win)
        r_burst_cnt <= '0;
      else if (w_l_win && !w_burst_full)
        r_burst_cnt <= r_burst_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Bench for imem_port_arbiter: issue-decision table, directed multi-cycle
// sequences, then random traffic against a transaction-level model.
module tb_imem_port_arbiter;

  localparam int unsigned LBM = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  imem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  imem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .LOAD_BURST_MAX(LBM)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  // ---------------- memory responder ----------------
  int unsigned lat_fixed  = 1;
  int unsigned rcnt       = 0;
  int unsigned stray_req  = 0;
  int unsigned stray_done = 0;
  logic [31:0] r_next;
  logic [31:0] mem [logic [31:0]];

  initial begin
    bus.mem_resp  = 1'b0;
    bus.mem_rdata = '0;
    r_next = '0;
    mem[32'h100] = 32'h0000_0013;
    forever begin
      @(negedge clk);
      if (bus.mem_req && reset_n) begin
        rcnt = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 4);
        if (bus.mem_we) begin
          mem[bus.mem_addr] = bus.mem_wdata;
          r_next = $urandom();
        end else begin
          r_next = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : dflt(bus.mem_addr);
        end
      end
      @(posedge clk); #1;
      bus.mem_resp = 1'b0;
      if (rcnt != 0) begin
        rcnt--;
        if (rcnt == 0) begin
          bus.mem_resp  = 1'b1;
          bus.mem_rdata = r_next;
        end
      end
      if (stray_req != stray_done) begin
        stray_done++;
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = 32'hBAD0_0000;
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    bus.f_req = 0; bus.f_addr = '0; bus.f_kill = 0;
    bus.l_req = 0; bus.l_we = 0; bus.l_addr = '0; bus.l_wdata = '0;
  endtask

  task automatic apply_reset();
    step();
    reset_n = 0;
    clear_inputs();
    step();
    step();
    reset_n = 1;
  endtask

  task automatic wait_quiet(input string name);
    int unsigned n = 0;
    while ((bus.busy || rcnt != 0) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy || rcnt != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s: still busy after %0d cycles, required idle", name, n);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- issue-decision table ----------------
  typedef struct {
    logic        f_req, f_kill, l_req, l_we;
    logic        e_req, e_gnt, e_we;
    logic [31:0] e_addr;
  } vec_t;

  vec_t vecs [8];

  // ---------------- random-phase model ----------------
  localparam int O_NONE = 0, O_FETCH = 1, O_LOAD = 2, O_DROP = 3;
  logic [31:0] ref_mem [logic [31:0]];

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] rnd_addr();
    return 32'h1000 + 32'($urandom_range(0, 15)) * 4;
  endfunction

  initial begin
    string grants;
    string exp_grants;
    int    own, streak;
    logic  m_err;
    logic  [31:0] own_addr, mf_data;
    logic  own_we;
    logic  ev_f_done, ev_kill, ev_l_gnt;
    logic  f_ok, e_f_iss, e_l_iss, e_f_resp, e_l_resp;
    int unsigned n;

    vecs[0] = '{0,0,0,0, 0,0,0, 32'h0};
    vecs[1] = '{1,0,0,0, 1,0,0, 32'h104};
    vecs[2] = '{1,1,0,0, 0,0,0, 32'h0};
    vecs[3] = '{0,0,1,0, 1,1,0, 32'h44};
    vecs[4] = '{0,0,1,1, 1,1,1, 32'h44};
    vecs[5] = '{1,0,1,0, 1,1,0, 32'h44};
    vecs[6] = '{1,1,1,1, 1,1,1, 32'h44};
    vecs[7] = '{0,1,0,0, 0,0,0, 32'h0};

    clear_inputs();
    apply_reset();
    @(negedge clk);
    chk("rst_mem_req",   bus.mem_req,   0);
    chk("rst_busy",      bus.busy,      0);
    chk("rst_err_stray", bus.err_stray, 0);
    chk("rst_l_gnt",     bus.l_gnt,     0);
    chk("rst_f_resp",    bus.f_resp,    0);
    chk("rst_l_resp",    bus.l_resp,    0);
    chk("rst_f_data",    bus.f_data,    0);
    chk("rst_l_rdata",   bus.l_rdata,   0);
    chk("rst_mem_addr",  bus.mem_addr,  0);

    // Table: single-cycle issue decisions from IDLE with burst count 0.
    lat_fixed = 1;
    for (int i = 0; i < 8; i++) begin
      apply_reset();
      step();
      bus.f_req = vecs[i].f_req; bus.f_kill = vecs[i].f_kill; bus.f_addr = 32'h104;
      bus.l_req = vecs[i].l_req; bus.l_we = vecs[i].l_we; bus.l_addr = 32'h44;
      bus.l_wdata = 32'h1111_0000 + 32'(i);
      @(negedge clk);
      chk($sformatf("vec%0d_mem_req", i), bus.mem_req, vecs[i].e_req);
      chk($sformatf("vec%0d_l_gnt", i),   bus.l_gnt,   vecs[i].e_gnt);
      if (vecs[i].e_req) begin
        chk($sformatf("vec%0d_mem_we", i),   bus.mem_we,   vecs[i].e_we);
        chk($sformatf("vec%0d_mem_addr", i), bus.mem_addr, vecs[i].e_addr);
      end
      step();
      clear_inputs();
      wait_quiet($sformatf("vec%0d_drain", i));
    end

    // A: fetch only, latency 1.
    apply_reset();
    lat_fixed = 1;
    step();
    bus.f_req = 1; bus.f_addr = 32'h100;
    @(negedge clk);
    chk("A_t0_mem_req", bus.mem_req, 1);
    chk("A_t0_addr",    bus.mem_addr, 32'h100);
    chk("A_t0_we",      bus.mem_we, 0);
    step();
    @(negedge clk);
    chk("A_t1_f_resp",  bus.f_resp, 1);
    chk("A_t1_f_data",  bus.f_data, 32'h13);
    chk("A_t1_mem_req", bus.mem_req, 0);
    step();
    bus.f_addr = 32'h104;
    @(negedge clk);
    chk("A_t2_mem_req", bus.mem_req, 1);
    chk("A_t2_f_data_hold", bus.f_data, 32'h13);
    step();
    clear_inputs();
    wait_quiet("A_drain");

    // B: loader write, latency 3.
    apply_reset();
    lat_fixed = 3;
    step();
    bus.l_req = 1; bus.l_we = 1; bus.l_addr = 32'h40; bus.l_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("B_t0_l_gnt",   bus.l_gnt, 1);
    chk("B_t0_mem_req", bus.mem_req, 1);
    chk("B_t0_we",      bus.mem_we, 1);
    chk("B_t0_addr",    bus.mem_addr, 32'h40);
    chk("B_t0_wdata",   bus.mem_wdata, 32'hDEAD_BEEF);
    chk("B_t0_busy",    bus.busy, 0);
    step();
    clear_inputs();
    for (int t = 1; t <= 4; t++) begin
      @(negedge clk);
      chk($sformatf("B_t%0d_busy", t),   bus.busy,   (t <= 3) ? 1'b1 : 1'b0);
      chk($sformatf("B_t%0d_l_resp", t), bus.l_resp, (t == 3) ? 1'b1 : 1'b0);
      if (t < 4) step();
    end
    wait_quiet("B_drain");

    // C: both requesters held, grant order bounded by the burst limit.
    apply_reset();
    lat_fixed = 1;
    step();
    bus.f_req = 1; bus.f_addr = 32'h100;
    bus.l_req = 1; bus.l_we = 0; bus.l_addr = 32'h48;
    grants = "";
    exp_grants = "LLLLFLLLLF";
    n = 0;
    while (grants.len() < 10 && n < 60) begin
      @(negedge clk);
      if (bus.mem_req) grants = {grants, bus.l_gnt ? "L" : "F"};
      n++;
      step();
    end
    chk("C_grant_count", 64'(grants.len()), 10);
    for (int i = 0; i < 10; i++) begin
      byte g;
      g = (i < grants.len()) ? grants[i] : "-";
      chk($sformatf("C_grant%0d", i), g, exp_grants[i]);
    end
    clear_inputs();
    wait_quiet("C_drain");

    // D: fetch killed while in flight, latency 4.
    apply_reset();
    lat_fixed = 4;
    step();
    bus.f_req = 1; bus.f_addr = 32'h180;
    @(negedge clk);
    chk("D_t0_mem_req", bus.mem_req, 1);
    step();
    bus.f_kill = 1;
    @(negedge clk);
    chk("D_t1_mem_req", bus.mem_req, 0);
    step();
    bus.f_kill = 0; bus.f_addr = 32'h200;
    for (int t = 2; t <= 5; t++) begin
      @(negedge clk);
      chk($sformatf("D_t%0d_f_resp", t),  bus.f_resp,  0);
      chk($sformatf("D_t%0d_l_resp", t),  bus.l_resp,  0);
      chk($sformatf("D_t%0d_mem_req", t), bus.mem_req, (t == 5) ? 1'b1 : 1'b0);
      chk($sformatf("D_t%0d_busy", t),    bus.busy,    (t == 5) ? 1'b0 : 1'b1);
      if (t == 5) chk("D_t5_addr", bus.mem_addr, 32'h200);
      step();
    end
    clear_inputs();
    wait_quiet("D_drain");

    // E: kill coincident with response, then kill held in IDLE.
    apply_reset();
    lat_fixed = 2;
    step();
    bus.f_req = 1; bus.f_addr = 32'h100;
    @(negedge clk);
    chk("E_t0_mem_req", bus.mem_req, 1);
    step();
    step();
    bus.f_kill = 1;
    @(negedge clk);
    chk("E_t2_f_resp",  bus.f_resp, 0);
    chk("E_t2_mem_req", bus.mem_req, 0);
    step();
    @(negedge clk);
    chk("E_t3_busy",    bus.busy, 0);
    chk("E_t3_mem_req", bus.mem_req, 0);
    chk("E_t3_f_data",  bus.f_data, 0);
    step();
    bus.f_kill = 0;
    @(negedge clk);
    chk("E_t4_mem_req", bus.mem_req, 1);
    step();
    clear_inputs();
    wait_quiet("E_drain");

    // F: spurious response in IDLE.
    apply_reset();
    @(negedge clk);
    stray_req++;
    step();
    @(negedge clk);
    chk("F_resp_cycle_f_resp", bus.f_resp, 0);
    chk("F_resp_cycle_l_resp", bus.l_resp, 0);
    chk("F_resp_cycle_err",    bus.err_stray, 0);
    step();
    @(negedge clk);
    chk("F_err_set", bus.err_stray, 1);
    step(); step();
    @(negedge clk);
    chk("F_err_sticky", bus.err_stray, 1);
    apply_reset();
    @(negedge clk);
    chk("F_err_cleared", bus.err_stray, 0);

    // G: reset during L_WAIT, late response arrives in IDLE.
    lat_fixed = 4;
    step();
    bus.l_req = 1; bus.l_we = 0; bus.l_addr = 32'h40;
    @(negedge clk);
    chk("G_t0_l_gnt", bus.l_gnt, 1);
    step();
    bus.l_req = 0;
    reset_n = 0;
    step();
    reset_n = 1;
    @(negedge clk);
    chk("G_t2_busy", bus.busy, 0);
    step(); step();
    @(negedge clk);
    chk("G_t4_l_resp", bus.l_resp, 0);
    step();
    @(negedge clk);
    chk("G_t5_err", bus.err_stray, 1);
    wait_quiet("G_drain");
    apply_reset();
    @(negedge clk);
    chk("G_err_cleared", bus.err_stray, 0);

    // Random traffic vs. transaction-level model.
    lat_fixed = 0;
    apply_reset();
    own = O_NONE; streak = 0; m_err = 0; own_addr = '0; own_we = 0; mf_data = '0;
    ev_f_done = 0; ev_kill = 0; ev_l_gnt = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      step();
      bus.f_kill = 0;
      if (!bus.f_req) begin
        if ($urandom_range(0, 1) != 0) begin bus.f_req = 1; bus.f_addr = rnd_addr(); end
      end else if (ev_f_done || ev_kill) begin
        bus.f_req = ($urandom_range(0, 3) != 0);
        bus.f_addr = rnd_addr();
      end
      if (bus.f_req && $urandom_range(0, 9) == 0) bus.f_kill = 1;
      if ((bus.l_req && ev_l_gnt) || (!bus.l_req && $urandom_range(0, 2) == 0)) begin
        bus.l_req = bus.l_req ? ($urandom_range(0, 1) != 0) : 1'b1;
        bus.l_we = ($urandom_range(0, 1) != 0);
        bus.l_addr = rnd_addr();
        bus.l_wdata = $urandom();
      end
      @(negedge clk);
      f_ok     = bus.f_req && !bus.f_kill;
      e_f_iss  = (own == O_NONE) && f_ok && (!bus.l_req || streak == LBM);
      e_l_iss  = (own == O_NONE) && bus.l_req && !e_f_iss;
      e_f_resp = (own == O_FETCH) && bus.mem_resp && !bus.f_kill;
      e_l_resp = (own == O_LOAD) && bus.mem_resp;
      if (e_f_resp) mf_data = ref_rd(own_addr);
      chk("R_mem_req", bus.mem_req, e_f_iss || e_l_iss);
      chk("R_l_gnt",   bus.l_gnt,   e_l_iss);
      if (e_f_iss || e_l_iss) begin
        chk("R_mem_addr", bus.mem_addr, e_l_iss ? bus.l_addr : bus.f_addr);
        chk("R_mem_we",   bus.mem_we,   e_l_iss && bus.l_we);
        if (e_l_iss && bus.l_we) chk("R_mem_wdata", bus.mem_wdata, bus.l_wdata);
      end
      chk("R_f_resp", bus.f_resp, e_f_resp);
      chk("R_l_resp", bus.l_resp, e_l_resp);
      chk("R_f_data", bus.f_data, mf_data);
      if (e_l_resp && !own_we) chk("R_l_rdata", bus.l_rdata, ref_rd(own_addr));
      chk("R_busy", bus.busy, own != O_NONE);
      chk("R_err",  bus.err_stray, m_err);
      if (own == O_NONE && bus.mem_resp) m_err = 1;
      if (own != O_NONE && bus.mem_resp) own = O_NONE;
      else if (own == O_FETCH && bus.f_kill) own = O_DROP;
      if (e_f_iss) begin own = O_FETCH; own_addr = bus.f_addr; own_we = 0; end
      if (e_l_iss) begin
        own = O_LOAD; own_addr = bus.l_addr; own_we = bus.l_we;
        if (bus.l_we) ref_mem[bus.l_addr] = bus.l_wdata;
      end
      if (!f_ok || e_f_iss) streak = 0;
      else if (e_l_iss && streak < LBM) streak++;
      ev_f_done = e_f_resp;
      ev_kill   = bus.f_kill;
      ev_l_gnt  = e_l_iss;
    end
    step();
    clear_inputs();
    wait_quiet("R_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
